// File: rtl/uart_pkg.sv
// Shared UART constants and receiver/transmitter FSM state encoding.
package uart_pkg;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 5208;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer; both flops reset to 1 so an idle line reads high.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_q    <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ready output register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD = uart_pkg::BAUD,
    parameter int HALF = BAUD / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [31:0] BIT_LIM  = 32'(BAUD - 1);
    localparam logic [31:0] HALF_LIM = 32'(HALF - 1);

    logic        w_rx_s;
    logic        w_fall;
    logic        w_half;
    logic        w_bit;
    logic        w_done;
    logic        w_take;
    logic        r_rx_prev;
    logic [1:0]  r_state;
    logic [31:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_dout;
    logic        r_valid;
    logic        r_fe;
    logic        r_ov;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    assign w_fall = r_rx_prev & ~w_rx_s;
    assign w_half = (r_cnt == HALF_LIM);
    assign w_bit  = (r_cnt == BIT_LIM);
    assign w_done = (r_state == S_STOP) & w_bit & w_rx_s;
    assign w_take = r_valid & ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_prev <= 1'b1;
            r_state   <= S_IDLE;
            r_cnt     <= 32'd0;
            r_idx     <= 3'd0;
            r_shift   <= 8'h00;
            r_fe      <= 1'b0;
        end else begin
            r_rx_prev <= w_rx_s;
            r_fe      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 32'd0;
                    if (w_fall) r_state <= S_START;
                end
                S_START: begin
                    if (w_half) begin
                        r_cnt   <= 32'd0;
                        r_idx   <= 3'd0;
                        r_state <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit) begin
                        r_shift[r_idx] <= w_rx_s;
                        r_cnt          <= 32'd0;
                        r_idx          <= r_idx + 3'd1;
                        if (r_idx == 3'd7) r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit) begin
                        r_cnt   <= 32'd0;
                        r_fe    <= ~w_rx_s;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                    r_cnt   <= 32'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A consume in the completion cycle frees the register for the new byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout  <= 8'h00;
            r_valid <= 1'b0;
            r_ov    <= 1'b0;
        end else begin
            r_ov <= 1'b0;
            if (w_done) begin
                if (!r_valid || ready) begin
                    r_dout  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ov <= 1'b1;
                end
            end else if (w_take) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign dout      = r_dout;
    assign valid     = r_valid;
    assign frame_err = r_fe;
    assign overrun   = r_ov;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD, default 5208, meaning clk cycles per bit (50 MHz, 9600 baud).
REQ-002 SHALL have parameter HALF, default BAUD/2, meaning clk cycles from the start-bit falling edge to the start-bit sample.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port dout, output, 8 bits: received byte, LSB received first.
REQ-007 SHALL have port valid, output, 1 bit: dout holds an unconsumed byte.
REQ-008 SHALL have port ready, input, 1 bit: consumer accepts dout when valid && ready.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-010 SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed byte is dropped.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); rx_s denotes the second flop; all decisions use rx_s only.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, with a 32-bit bit-timer cnt and a 3-bit bit index idx.
REQ-013 IDLE: on a falling edge of rx_s (previous 1, current 0) SHALL go to START with cnt=0; a line held low (break) SHALL NOT retrigger.
REQ-014 START: at cnt==HALF-1, if rx_s==0 SHALL go to DATA with cnt=0 and idx=0; otherwise SHALL return to IDLE (glitch reject, no flags).
REQ-015 DATA: at cnt==BAUD-1 SHALL sample rx_s into shift bit idx, set cnt=0, and increment idx; after idx==7 is sampled SHALL go to STOP.
REQ-016 STOP: at cnt==BAUD-1, if rx_s==1 the byte is complete; if rx_s==0 SHALL pulse frame_err for one cycle and discard the byte; SHALL return to IDLE in both cases.
REQ-017 cnt SHALL count 0..limit-1 and restart; it SHALL be held at 0 in IDLE.
REQ-018 A completed byte SHALL appear on dout with valid=1 on the cycle after the stop-bit sample (latency 1 clk).
REQ-019 valid SHALL stay high, and dout SHALL stay stable, until a cycle with valid && ready; valid SHALL drop the following cycle unless a new byte loads in that same cycle.
REQ-020 If a byte completes while valid && !ready, SHALL pulse overrun for one cycle, keep the old dout, and drop the new byte.
REQ-021 If a byte completes in the same cycle as valid && ready, SHALL load the new byte, keep valid=1, and SHALL NOT pulse overrun.
REQ-022 ready SHALL be ignored while valid==0.
REQ-023 frame_err and overrun SHALL never be asserted for more than one consecutive cycle per event.

Reset
REQ-024 On rst=1 at a clk edge: state=IDLE, cnt=0, idx=0, shift register=0, dout=8'h00, valid=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-025 Reset mid-frame SHALL abandon the frame with no flag; after release the receiver SHALL wait for a fresh falling edge.

Structure
REQ-026 Package uart_pkg SHALL hold BAUD, CLK_HZ (50_000_000), and the FSM state encoding, shared with the existing transmitter.
REQ-027 The block SHALL contain one sub-module, uart_sync2 (2-flop synchronizer with reset value 1); all other logic is inline.

Verification
REQ-028 Scenario: send 8'h61 ("a") at BAUD=5208 with ready=1 -> valid pulses for one cycle with dout=8'h61, 1 cycle after the stop sample; frame_err=0, overrun=0.
REQ-029 Scenario: rx low for 1000 cycles then high -> START rejects the glitch, back to IDLE; no valid, no flags.
REQ-030 Scenario: send 8'hA5 with the stop bit forced low -> frame_err pulses for one cycle, valid stays 0; the line held low does not start a new frame until rx returns high and falls again.
REQ-031 Scenario: send 8'h11 then 8'h22 back-to-back with ready=0 -> dout=8'h11 with valid held; overrun pulses at completion of 8'h22; dout stays 8'h11.
REQ-032 Scenario: valid=1 with dout=8'h33, ready asserted exactly in the cycle 8'h44 completes -> dout=8'h44, valid stays 1, overrun=0.
REQ-033 Scenario: assert rst during bit 4 of 8'hFF -> all outputs reset; the next full frame 8'h5A is received correctly.
